// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer: START, {addr,rw}, ACK, one data byte,
// ACK/NACK, STOP. Advances one quarter-bit phase per tick_4x pulse and
// drives open-drain style enables (1 = release, 0 = pull low).
module i2c_master_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_4x,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
  } state_t;

  state_t     state;
  logic [1:0] phase;
  logic [2:0] bit_idx;
  logic [7:0] addr_byte;
  logic [7:0] wr_byte;
  logic [7:0] rx_sh;
  logic       rd;
  logic       tx_bit;

  // Bit currently being serialised; reads release SDA during the data byte.
  always_comb begin
    tx_bit = 1'b1;
    if (state == S_ADDR)     tx_bit = addr_byte[bit_idx];
    else if (!rd)            tx_bit = wr_byte[bit_idx];
  end

  // Sequencer: one transaction per accepted request, phase steps on tick_4x.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      phase     <= 2'd0;
      bit_idx   <= 3'd7;
      scl_o     <= 1'b1;
      sda_o     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      rdata     <= 8'h00;
      addr_byte <= 8'h00;
      wr_byte   <= 8'h00;
      rx_sh     <= 8'h00;
      rd        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        scl_o <= 1'b1;
        sda_o <= 1'b1;
        if (start) begin
          addr_byte <= {addr, rw};
          rd        <= rw;
          wr_byte   <= wdata;
          ack_err   <= 1'b0;
          busy      <= 1'b1;
          phase     <= 2'd0;
          state     <= S_START;
        end
      end else if (tick_4x) begin
        phase <= phase + 2'd1;
        case (state)
          S_START: begin
            // SDA falls while SCL is high, then SCL drops to begin bit 7.
            case (phase)
              2'd2: sda_o <= 1'b0;
              2'd3: begin
                scl_o   <= 1'b0;
                bit_idx <= 3'd7;
                state   <= S_ADDR;
              end
              default: begin
                scl_o <= 1'b1;
                sda_o <= 1'b1;
              end
            endcase
          end
          S_ADDR, S_DATA: begin
            scl_o <= phase[1];
            if (phase == 2'd0) sda_o <= tx_bit;
            if (phase == 2'd2 && state == S_DATA) rx_sh <= {rx_sh[6:0], sda_i};
            if (phase == 2'd3) begin
              if (bit_idx == 3'd0) begin
                bit_idx <= 3'd7;
                state   <= (state == S_ADDR) ? S_ACK1 : S_ACK2;
              end else begin
                bit_idx <= bit_idx - 3'd1;
              end
            end
          end
          S_ACK1, S_ACK2: begin
            // Master releases SDA: slave ACK slot, or master NACK on reads.
            scl_o <= phase[1];
            if (phase == 2'd0) sda_o <= 1'b1;
            if (phase == 2'd2 && sda_i && (state == S_ACK1 || !rd)) ack_err <= 1'b1;
            if (phase == 2'd3) begin
              if (state == S_ACK1) begin
                state <= ack_err ? S_STOP : S_DATA;
              end else begin
                if (rd) rdata <= rx_sh;
                state <= S_STOP;
              end
            end
          end
          S_STOP: begin
            case (phase)
              2'd0: begin
                scl_o <= 1'b0;
                sda_o <= 1'b0;
              end
              2'd1: scl_o <= 1'b1;
              2'd3: begin
                sda_o <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end
              default: ;
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a tick-indexed slave model drives
// sda_i, SDA is captured on every SCL rising edge, and each scenario task
// checks its own results.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_4x = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       sda_i;
  logic       scl_o, sda_o, busy, done, ack_err;
  logic [7:0] rdata;

  i2c_master_ctrl dut (
    .clk(clk), .rst(rst), .tick_4x(tick_4x), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Wired-AND bus: either side may pull SDA low.
  logic slave_out = 1'b1;
  assign sda_i = sda_o & slave_out;

  int passed = 0;
  int total  = 0;

  // Slave scenario and per-transaction capture state.
  logic       s_ack1, s_ack2, s_rd;
  logic [7:0] s_rbyte;
  int         k;
  int         done_tick;
  int         rises;
  logic       prev_scl;
  logic       cap_bits [0:31];

  // Slave pulls SDA according to where the transaction is by tick index.
  function automatic logic slave_level(int t);
    if (t >= 36 && t < 40) return s_ack1;
    if (s_rd && t >= 40 && t < 72) return s_rbyte[7 - ((t - 40) / 4)];
    if (!s_rd && t >= 72 && t < 76) return s_ack2;
    return 1'b1;
  endfunction

  function automatic logic [7:0] cap_byte(int first);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8; i++) b = {b[6:0], cap_bits[first + i]};
    return b;
  endfunction

  task automatic begin_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input logic ack1, input logic ack2, input logic [7:0] rb);
    s_ack1 = ack1; s_ack2 = ack2; s_rd = r; s_rbyte = rb;
    k = 0; done_tick = -1; rises = 0; prev_scl = scl_o;
    for (int i = 0; i < 32; i++) cap_bits[i] = 1'b0;
    addr = a; rw = r; wdata = wd; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One tick period: tick pulse, then three idle cycles.
  task automatic tick_once();
    slave_out = slave_level(k);
    tick_4x = 1'b1;
    @(posedge clk); #1 tick_4x = 1'b0;
    k++;
    if (scl_o && !prev_scl && rises < 32) begin
      cap_bits[rises] = sda_o;
      rises++;
    end
    prev_scl = scl_o;
    if (done && done_tick < 0) done_tick = k;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_to_done();
    while (done_tick < 0 && k < 100) tick_once();
    slave_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (scl_o !== 1'b1) $display("FAIL reset_scl got %b want 1", scl_o); else passed++;
    total++; if (sda_o !== 1'b1) $display("FAIL reset_sda got %b want 1", sda_o); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err got %b want 0", ack_err); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else passed++;
  endtask

  task automatic test_write();
    begin_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    total++; if (busy !== 1'b1) $display("FAIL wr_busy_accept got %b want 1", busy); else passed++;
    run_to_done();
    total++; if (done_tick !== 80) $display("FAIL wr_ticks got %0d want 80", done_tick); else passed++;
    total++; if (cap_byte(0) !== 8'hA0) $display("FAIL wr_addr_byte got %h want a0", cap_byte(0)); else passed++;
    total++; if (cap_byte(9) !== 8'hA5) $display("FAIL wr_data_byte got %h want a5", cap_byte(9)); else passed++;
    total++; if (ack_err !== 1'b0) $display("FAIL wr_ack_err got %b want 0", ack_err); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL wr_busy_done got %b want 0", busy); else passed++;
    total++; if ({scl_o, sda_o} !== 2'b11) $display("FAIL wr_lines got %b want 11", {scl_o, sda_o}); else passed++;
    total++; if (done !== 1'b0) $display("FAIL wr_done_pulse got %b want 0", done); else passed++;
  endtask

  task automatic test_read();
    begin_txn(7'h50, 1'b1, 8'h00, 1'b0, 1'b1, 8'h3C);
    run_to_done();
    total++; if (done_tick !== 80) $display("FAIL rd_ticks got %0d want 80", done_tick); else passed++;
    total++; if (cap_byte(0) !== 8'hA1) $display("FAIL rd_addr_byte got %h want a1", cap_byte(0)); else passed++;
    total++; if (rdata !== 8'h3C) $display("FAIL rd_rdata got %h want 3c", rdata); else passed++;
    total++; if (cap_bits[17] !== 1'b1) $display("FAIL rd_master_nack got %b want 1", cap_bits[17]); else passed++;
    total++; if (ack_err !== 1'b0) $display("FAIL rd_ack_err got %b want 0", ack_err); else passed++;
  endtask

  task automatic test_addr_nack();
    begin_txn(7'h21, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
    run_to_done();
    total++; if (done_tick !== 44) $display("FAIL nack_ticks got %0d want 44", done_tick); else passed++;
    total++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err got %b want 1", ack_err); else passed++;
    total++; if (cap_byte(0) !== 8'h42) $display("FAIL nack_addr_byte got %h want 42", cap_byte(0)); else passed++;
    total++; if (rises !== 10) $display("FAIL nack_scl_rises got %0d want 10", rises); else passed++;
    total++; if ({scl_o, sda_o} !== 2'b11) $display("FAIL nack_lines got %b want 11", {scl_o, sda_o}); else passed++;
  endtask

  task automatic test_data_nack();
    begin_txn(7'h50, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h00);
    run_to_done();
    total++; if (done_tick !== 80) $display("FAIL dnack_ticks got %0d want 80", done_tick); else passed++;
    total++; if (ack_err !== 1'b1) $display("FAIL dnack_ack_err got %b want 1", ack_err); else passed++;
    total++; if (cap_byte(9) !== 8'h0F) $display("FAIL dnack_data_byte got %h want 0f", cap_byte(9)); else passed++;
    total++; if (rdata !== 8'h3C) $display("FAIL dnack_rdata_held got %h want 3c", rdata); else passed++;
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    begin_txn(7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00);
    repeat (50) tick_once();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    total++; if ({scl_o, sda_o} !== 2'b11) $display("FAIL rstmid_lines got %b want 11", {scl_o, sda_o}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    done_seen = done;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    total++; if (done_seen !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", done_seen); else passed++;
    begin_txn(7'h50, 1'b0, 8'h96, 1'b0, 1'b0, 8'h00);
    run_to_done();
    total++; if (done_tick !== 80) $display("FAIL rstmid_rerun_ticks got %0d want 80", done_tick); else passed++;
    total++; if (cap_byte(9) !== 8'h96) $display("FAIL rstmid_rerun_data got %h want 96", cap_byte(9)); else passed++;
  endtask

  task automatic test_busy_ignore();
    logic scl_hold, sda_hold;
    int   moved = 0;
    begin_txn(7'h50, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00);
    repeat (22) tick_once();
    addr = 7'h7F; wdata = 8'hFF; rw = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scl_hold = scl_o; sda_hold = sda_o;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (scl_o !== scl_hold || sda_o !== sda_hold) moved++;
    end
    total++; if (moved !== 0) $display("FAIL freeze_lines got %0d changes want 0", moved); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL freeze_busy got %b want 1", busy); else passed++;
    run_to_done();
    total++; if (done_tick !== 80) $display("FAIL ignore_ticks got %0d want 80", done_tick); else passed++;
    total++; if (cap_byte(0) !== 8'hA0) $display("FAIL ignore_addr got %h want a0", cap_byte(0)); else passed++;
    total++; if (cap_byte(9) !== 8'h5A) $display("FAIL ignore_data got %h want 5a", cap_byte(9)); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL ignore_rdata got %h want 00", rdata); else passed++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_reset_mid();
    test_busy_ignore();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
